// File: rtl/phase_shift_monitor_if.sv
// Purpose : signal bundle between a phase_shift_monitor and its driver
//           (sampled clocks, lock, per-channel targets in; period/valid/fail/timeout out).
// Ports   : master = stimulus side (drives i_*), slave = monitor side (drives o_*).
//           o_err_max exists only when PHASE_MON_ERR_CAPTURE_EN is defined.
interface phase_shift_monitor_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16
);
  logic                   i_locked;
  logic                   i_ref_in;
  logic [N_CH-1:0]        i_sig_in;
  logic [32*N_CH-1:0]     i_desired_shift_1000;
  logic [31:0]            i_tol_1000;
  logic [CNT_W-1:0]       o_period;
  logic [N_CH-1:0]        o_valid;
  logic [N_CH-1:0]        o_fail;
  logic                   o_timeout;
`ifdef PHASE_MON_ERR_CAPTURE_EN
  logic [32*N_CH-1:0]     o_err_max;

  modport master (
    output i_locked, i_ref_in, i_sig_in, i_desired_shift_1000, i_tol_1000,
    input  o_period, o_valid, o_fail, o_timeout, o_err_max
  );
  modport slave (
    input  i_locked, i_ref_in, i_sig_in, i_desired_shift_1000, i_tol_1000,
    output o_period, o_valid, o_fail, o_timeout, o_err_max
  );
`else
  modport master (
    output i_locked, i_ref_in, i_sig_in, i_desired_shift_1000, i_tol_1000,
    input  o_period, o_valid, o_fail, o_timeout
  );
  modport slave (
    input  i_locked, i_ref_in, i_sig_in, i_desired_shift_1000, i_tol_1000,
    output o_period, o_valid, o_fail, o_timeout
  );
`endif
endinterface

// File: rtl/phase_shift_monitor.sv
// Purpose : N-channel phase checker; measures ref period and per-channel rising-edge
//           delay on clk, compares against desired shift (millidegrees) +/- tolerance.
// Latency : edge detect trails pins by 3 ticks; o_valid[i] 1 cycle after the channel
//           edge is detected, o_fail[i] reflects that comparison 1 cycle after o_valid[i].
// Backpressure: none; results are pulses/sticky flags, nothing waits on a consumer.
// Ports   : clk (sampling clock), rst (async, active-high), bus (phase_shift_monitor_if.slave):
//           i_locked, i_ref_in, i_sig_in[N_CH], i_desired_shift_1000[32*N_CH] (signed, ch i at
//           [32i+:32]), i_tol_1000 (unsigned) -> o_period, o_valid, o_fail (sticky), o_timeout (sticky).
// Option  : define PHASE_MON_ERR_CAPTURE_EN to add o_err_max (largest |err|/period per channel).
module phase_shift_monitor #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16,
  parameter int SKIP  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  phase_shift_monitor_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int               SK_W    = (SKIP < 2) ? 1 : $clog2(SKIP + 1);

  typedef enum logic [1:0] {G_IDLE, G_SETTLE, G_RUN} g_state_t;
  typedef enum logic [1:0] {C_ARM, C_WAIT, C_CMP} c_state_t;

  // Wrapped absolute phase error in tick*millidegree units.
  function automatic logic signed [63:0] f_abs_err(
    input logic        [CNT_W-1:0] dly,
    input logic        [CNT_W-1:0] per,
    input logic signed [31:0]      des
  );
    logic signed [63:0] v_p;
    logic signed [63:0] v_dl;
    logic signed [63:0] v_d;
    logic signed [63:0] v_e;
    v_p  = $signed({{(64-CNT_W){1'b0}}, per});
    v_dl = (per == '0) ? 64'sd0 : $signed({{(64-CNT_W){1'b0}}, dly % per});
    // Signed % truncates toward zero, so fold negatives back into [0,360000).
    v_d  = $signed({{32{des[31]}}, des}) % 64'sd360000;
    if (v_d < 0) v_d = v_d + 64'sd360000;
    v_e  = v_dl * 64'sd360000 - v_d * v_p;
    if (v_e > v_p * 64'sd180000)
      v_e = v_e - v_p * 64'sd360000;
    else if (v_e < -(v_p * 64'sd180000))
      v_e = v_e + v_p * 64'sd360000;
    return (v_e < 0) ? -v_e : v_e;
  endfunction

  // 2-flop synchronizers plus one edge-detect flop; identical depth on every input.
  logic            r_ref_s1, r_ref_s2, r_ref_d;
  logic [N_CH-1:0] r_sig_s1, r_sig_s2, r_sig_d;
  logic            w_ref_edge;
  logic [N_CH-1:0] w_sig_edge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ref_s1 <= 1'b0;
      r_ref_s2 <= 1'b0;
      r_ref_d  <= 1'b0;
      r_sig_s1 <= '0;
      r_sig_s2 <= '0;
      r_sig_d  <= '0;
    end else begin
      r_ref_s1 <= bus.i_ref_in;
      r_ref_s2 <= r_ref_s1;
      r_ref_d  <= r_ref_s2;
      r_sig_s1 <= bus.i_sig_in;
      r_sig_s2 <= r_sig_s1;
      r_sig_d  <= r_sig_s2;
    end
  end

  assign w_ref_edge = r_ref_s2 & ~r_ref_d;
  assign w_sig_edge = r_sig_s2 & ~r_sig_d;

  // Reference period counter; saturates at CNT_MAX and flags timeout.
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic             r_timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_period  <= '0;
      r_timeout <= 1'b0;
    end else if (w_ref_edge) begin
      r_period <= r_cnt;
      r_cnt    <= {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_timeout <= 1'b1;
    end
  end

  // Global lock/settle FSM.
  g_state_t        r_gst;
  logic [SK_W-1:0] r_skip;
  logic            w_run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gst  <= G_IDLE;
      r_skip <= '0;
    end else if (!bus.i_locked) begin
      r_gst  <= G_IDLE;
      r_skip <= '0;
    end else begin
      case (r_gst)
        G_IDLE: begin
          r_skip <= '0;
          r_gst  <= (SKIP == 0) ? G_RUN : G_SETTLE;
        end
        G_SETTLE: begin
          if (w_ref_edge) begin
            if (32'(r_skip) == SKIP - 1) r_gst  <= G_RUN;
            else                         r_skip <= r_skip + 1'b1;
          end
        end
        G_RUN:   r_gst <= G_RUN;
        default: r_gst <= G_IDLE;
      endcase
    end
  end

  // Gate with the raw lock so a falling lock silences channels in the same cycle.
  assign w_run = (r_gst == G_RUN) && bus.i_locked;

  // Per-channel measurement state.
  c_state_t         r_cst [N_CH];
  logic [CNT_W-1:0] r_dly [N_CH];
  logic [CNT_W-1:0] r_cap [N_CH];
  logic [N_CH-1:0]  r_miss;
  logic [N_CH-1:0]  r_rearm;
  logic [N_CH-1:0]  r_valid;
  logic [N_CH-1:0]  r_fail;

  logic signed [63:0] w_abs [N_CH];
  logic signed [63:0] w_tol_p;
  logic [N_CH-1:0]    w_bad;

  assign w_tol_p = $signed({32'd0, bus.i_tol_1000}) * $signed({{(64-CNT_W){1'b0}}, r_period});

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      w_abs[i] = f_abs_err(r_cap[i], r_period, $signed(bus.i_desired_shift_1000[32*i +: 32]));
      w_bad[i] = r_miss[i] || (r_period == '0) || (w_abs[i] > w_tol_p);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        r_cst[i] <= C_ARM;
        r_dly[i] <= '0;
        r_cap[i] <= '0;
      end
      r_miss  <= '0;
      r_rearm <= '0;
      r_valid <= '0;
      r_fail  <= '0;
    end else begin
      r_valid <= '0;
      for (int i = 0; i < N_CH; i++) begin
        // A comparison already announced by o_valid always commits, even if lock just fell.
        if (r_cst[i] == C_CMP && w_bad[i]) r_fail[i] <= 1'b1;
        if (!w_run) begin
          r_cst[i]   <= C_ARM;
          r_dly[i]   <= '0;
          r_rearm[i] <= 1'b0;
        end else begin
          case (r_cst[i])
            C_ARM: begin
              if (w_ref_edge) begin
                r_dly[i] <= '0;
                r_cst[i] <= C_WAIT;
              end
            end
            C_WAIT: begin
              if (r_dly[i] != CNT_MAX) r_dly[i] <= r_dly[i] + 1'b1;
              if (w_ref_edge) begin
                // Ref edge closes the window: delay = full period (0 deg after mod);
                // the same edge starts the next measurement.
                r_cap[i]   <= r_cnt;
                r_miss[i]  <= ~w_sig_edge[i];
                r_rearm[i] <= 1'b1;
                r_dly[i]   <= '0;
                r_valid[i] <= 1'b1;
                r_cst[i]   <= C_CMP;
              end else if (w_sig_edge[i]) begin
                r_cap[i]   <= r_dly[i] + 1'b1;
                r_miss[i]  <= 1'b0;
                r_rearm[i] <= 1'b0;
                r_valid[i] <= 1'b1;
                r_cst[i]   <= C_CMP;
              end
            end
            C_CMP: begin
              if (r_dly[i] != CNT_MAX) r_dly[i] <= r_dly[i] + 1'b1;
              r_cst[i] <= r_rearm[i] ? C_WAIT : C_ARM;
            end
            default: r_cst[i] <= C_ARM;
          endcase
        end
      end
    end
  end

`ifdef PHASE_MON_ERR_CAPTURE_EN
  logic [32*N_CH-1:0] r_err_max;
  logic [31:0]        w_err_deg [N_CH];
  logic signed [63:0] w_quot    [N_CH];

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      w_quot[i]    = (r_period == '0) ? 64'sd0
                   : w_abs[i] / $signed({{(64-CNT_W){1'b0}}, r_period});
      w_err_deg[i] = 32'(w_quot[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_max <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (r_cst[i] == C_CMP && w_err_deg[i] > r_err_max[32*i +: 32])
          r_err_max[32*i +: 32] <= w_err_deg[i];
      end
    end
  end

  assign bus.o_err_max = r_err_max;
`endif

  assign bus.o_period  = r_period;
  assign bus.o_valid   = r_valid;
  assign bus.o_fail    = r_fail;
  assign bus.o_timeout = r_timeout;

endmodule

// File: tb/tb_phase_shift_monitor.sv
// Purpose : directed bench for phase_shift_monitor with a queue-based scoreboard.
// Ports   : none; drives the DUT through a phase_shift_monitor_if instance.
module tb_phase_shift_monitor;
  localparam int N_CH  = 4;
  localparam int CNT_W = 16;
  localparam int SKIP  = 2;
  localparam int PER   = 100;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  phase_shift_monitor_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

  phase_shift_monitor #(.N_CH(N_CH), .CNT_W(CNT_W), .SKIP(SKIP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Clock-pattern generator: ref high for phases 0..49; channel i lags by lag[i] ticks.
  int ph        = 0;
  int ref_edges = 0;
  bit ref_run   = 1'b0;
  int lag [N_CH];
  bit en  [N_CH];

  initial begin
    forever begin
      @(negedge clk);
      ph = (ph + 1) % PER;
      if (ref_run && ph == 0) ref_edges++;
      bus.i_ref_in = ref_run && (ph < PER/2);
      for (int i = 0; i < N_CH; i++)
        bus.i_sig_in[i] = en[i] && (((ph - lag[i] + PER) % PER) < PER/2);
    end
  end

  // Scoreboard: per-channel queue of {expected fail after compare, expected period}.
  typedef struct packed {
    logic             f;
    logic [CNT_W-1:0] per;
  } exp_t;

  exp_t q_exp [N_CH][$];
  bit   quiet      = 1'b0;
  int   quiet_hits = 0;
  bit   seen_first = 1'b0;
  int   first_edge = -1;
  bit   pend   [N_CH];
  logic pend_f [N_CH];

  initial begin
    exp_t e;
    for (int i = 0; i < N_CH; i++) pend[i] = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N_CH; i++) begin
        if (pend[i]) begin
          check($sformatf("fail_ch%0d", i), longint'(bus.o_fail[i]), longint'(pend_f[i]));
          pend[i] = 1'b0;
        end
      end
      if (quiet && bus.o_valid != '0) quiet_hits++;
      if (!seen_first && bus.o_valid[0]) begin
        seen_first = 1'b1;
        first_edge = ref_edges;
      end
      for (int i = 0; i < N_CH; i++) begin
        if (bus.o_valid[i] && q_exp[i].size() > 0) begin
          e = q_exp[i].pop_front();
          check($sformatf("period_at_valid_ch%0d", i), longint'(bus.o_period), longint'(e.per));
          pend[i]   = 1'b1;
          pend_f[i] = e.f;
        end
      end
    end
  end

  task automatic wait_ph(input int p);
    do @(posedge clk); while (ph != p);
    #2;
  endtask

  task automatic push(input int ch, input logic f, input int n);
    exp_t e;
    e.f   = f;
    e.per = CNT_W'(PER);
    for (int k = 0; k < n; k++) q_exp[ch].push_back(e);
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N_CH; i++) s += q_exp[i].size();
    return s;
  endfunction

  task automatic drain(input string name, input int budget);
    int c = 0;
    while (pending() != 0 && c < budget) begin
      @(posedge clk);
      c++;
    end
    check({name, "_all_valids_seen"}, longint'(pending()), 0);
    for (int i = 0; i < N_CH; i++) q_exp[i].delete();
    repeat (2) @(posedge clk);
    #2;
  endtask

  initial begin
    int c;
    rst                      = 1'b1;
    bus.i_locked             = 1'b0;
    bus.i_ref_in             = 1'b0;
    bus.i_sig_in             = '0;
    bus.i_tol_1000           = 32'd5000;
    bus.i_desired_shift_1000 = '0;
    bus.i_desired_shift_1000[0  +: 32] = 32'sd90000;
    bus.i_desired_shift_1000[32 +: 32] = -32'sd90000;
    bus.i_desired_shift_1000[64 +: 32] = 32'sd90000;
    bus.i_desired_shift_1000[96 +: 32] = 32'sd0;
    lag = '{25, 75, 30, 0};
    en  = '{1'b1, 1'b1, 1'b1, 1'b0};

    // Reset and idle (ref stopped, unlocked).
    repeat (3) @(posedge clk);
    #2;
    check("rst_period",  longint'(bus.o_period),  0);
    check("rst_valid",   longint'(bus.o_valid),   0);
    check("rst_fail",    longint'(bus.o_fail),    0);
    check("rst_timeout", longint'(bus.o_timeout), 0);
    rst   = 1'b0;
    quiet = 1'b1;
    repeat (200) @(posedge clk);
    #2;
    check("idle_period",       longint'(bus.o_period),  0);
    check("idle_fail",         longint'(bus.o_fail),    0);
    check("idle_timeout",      longint'(bus.o_timeout), 0);
    check("idle_valid_pulses", longint'(quiet_hits),    0);
    quiet = 1'b0;

    // Lock with ch0 +90deg ok, ch1 -90deg ok, ch2 108deg bad, ch3 stuck low.
    wait_ph(60);
    ref_run = 1'b1;
    repeat (3*PER) @(posedge clk);
    push(0, 1'b0, 2);
    push(1, 1'b0, 2);
    push(2, 1'b1, 2);
    push(3, 1'b1, 2);
    wait_ph(50);
    seen_first   = 1'b0;
    ref_edges    = 0;
    bus.i_locked = 1'b1;
    drain("run", 800);
    check("first_valid_ref_period", longint'(first_edge), 3);
    check("fail_after_run",         longint'(bus.o_fail), 4'b1100);

    // Fix ch2 to 90deg: its fail flag must stay set.
    wait_ph(50);
    lag[2] = 25;
    push(2, 1'b1, 2);
    push(0, 1'b0, 2);
    drain("fixed", 400);
    check("sticky_fail_ch2", longint'(bus.o_fail[2]), 1);

    // Drop lock while channels wait for their edges.
    wait_ph(10);
    quiet_hits   = 0;
    quiet        = 1'b1;
    bus.i_locked = 1'b0;
    repeat (300) @(posedge clk);
    #2;
    check("unlock_valid_pulses", longint'(quiet_hits), 0);
    check("unlock_fail_kept",    longint'(bus.o_fail), 4'b1100);
    quiet = 1'b0;

    // Relock, then reset mid-run.
    wait_ph(50);
    bus.i_locked = 1'b1;
    repeat (450) @(posedge clk);
    #2;
    check("relock_fail_kept", longint'(bus.o_fail), 4'b1100);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midrst_period",  longint'(bus.o_period),  0);
    check("midrst_valid",   longint'(bus.o_valid),   0);
    check("midrst_fail",    longint'(bus.o_fail),    0);
    check("midrst_timeout", longint'(bus.o_timeout), 0);
    bus.i_locked = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;

    // Stop ref: timeout after the counter saturates (~65535 ticks after last edge).
    repeat (300) @(posedge clk);
    wait_ph(50);
    check("period_before_stop",  longint'(bus.o_period),  PER);
    check("timeout_before_stop", longint'(bus.o_timeout), 0);
    ref_run = 1'b0;
    repeat (65300) @(posedge clk);
    #2;
    check("timeout_early", longint'(bus.o_timeout), 0);
    c = 0;
    while (!bus.o_timeout && c < 400) begin
      @(posedge clk);
      #2;
      c++;
    end
    check("timeout_set", longint'(bus.o_timeout), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
